// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM encodings for the ALU-64 logic datapath and its arbiter.
package alu_pkg;
  localparam int unsigned ALU_WIDTH = 64;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_NOTB = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/logic_req_arbiter_if.sv
// Request/response bundle between issue-stage requesters and logic_req_arbiter.
interface logic_req_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][2:0]       req_op;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic                          resp_valid;
  logic                          resp_ready;
  logic                          resp_id;
  logic [WIDTH-1:0]              resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit; sel uses the alu_pkg OP_* encoding.
module logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = '0;
    case (sel)
      OP_AND:  out = in_0 & in_1;
      OP_NAND: out = ~(in_0 & in_1);
      OP_OR:   out = in_0 | in_1;
      OP_NOR:  out = ~(in_0 | in_1);
      OP_XOR:  out = in_0 ^ in_1;
      OP_XNOR: out = ~(in_0 ^ in_1);
      OP_NOTA: out = ~in_0;
      OP_NOTB: out = ~in_1;
    endcase
  end
endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grant is one-hot or zero, ptr names the preferred requester.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
      // The winner goes to the back of the line.
      if (|gnt) ptr_nxt = ~gnt[1];
    end
  end
endmodule

// File: rtl/logic_req_arbiter.sv
// Shares one logic_unit between two requesters with a single tagged response channel.
// Optional LOGIC_ARB_STATS_EN adds per-requester 32-bit grant counters.
module logic_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_req_arbiter_if.slave    bus,
  output logic                  busy
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1
`endif
);
  logic [1:0]         state;
  logic               rr_ptr;
  logic               ptr_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic               win_id;
  logic [2:0]         cap_op;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic [WIDTH-1:0]   lu_out;
  logic               resp_id_q;
  logic [WIDTH-1:0]   resp_data_q;

  rr_arbiter2 u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .en      (state == ST_IDLE),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .in_0 (cap_a),
    .in_1 (cap_b),
    .sel  (cap_op),
    .out  (lu_out)
  );

  assign win_id         = gnt[1];
  assign bus.req_ready  = gnt;
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      cap_op      <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      resp_id_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            cap_op    <= bus.req_op[win_id];
            cap_a     <= bus.req_a[win_id];
            cap_b     <= bus.req_b[win_id];
            resp_id_q <= win_id;
            rr_ptr    <= ptr_nxt;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_data_q <= lu_out;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt[0]) cnt0_q <= cnt0_q + 32'd1;
      if (gnt[1]) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif
endmodule
